// File: rtl/cmp_scheduler.sv
// rtl/cmp_scheduler.sv - round-robin sharing of one comparator between two requesters
module cmp_scheduler #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic             rsp_eq,
    output logic             rsp_gt,
    output logic             rsp_lt,
    output logic [WIDTH-1:0] cmp_a,
    output logic [WIDTH-1:0] cmp_b,
    input  logic             cmp_eq,
    input  logic             cmp_gt,
    input  logic             cmp_lt,
    output logic             busy,
    output logic             proto_err,
    output logic [15:0]      cmp_count
);
    typedef enum logic [1:0] {IDLE, COMPARE, RESPOND} state_t;

    state_t state, state_nxt;
    logic   last_grant;
    logic   owner;
    logic   armed;
    logic   grant;
    logic   accept;
    logic   rsp_done;
    logic   flags_onehot;

    assign flags_onehot = ({cmp_eq, cmp_gt, cmp_lt} == 3'b100) ||
                          ({cmp_eq, cmp_gt, cmp_lt} == 3'b010) ||
                          ({cmp_eq, cmp_gt, cmp_lt} == 3'b001);
    assign busy = (state != IDLE);

    // armed keeps req_ready low until the first edge after reset release
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        accept    = 1'b0;
        rsp_done  = 1'b0;
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        case (state)
            IDLE: begin
                if (req_valid == 2'b11) grant = ~last_grant;
                else                    grant = req_valid[1];
                if (armed && (req_valid != 2'b00)) begin
                    req_ready[grant] = 1'b1;
                    accept           = 1'b1;
                    state_nxt        = COMPARE;
                end
            end
            COMPARE: state_nxt = RESPOND;
            RESPOND: begin
                rsp_valid[owner] = 1'b1;
                if (rsp_ready[owner]) begin
                    rsp_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            armed      <= 1'b0;
            cmp_a      <= '0;
            cmp_b      <= '0;
            rsp_eq     <= 1'b0;
            rsp_gt     <= 1'b0;
            rsp_lt     <= 1'b0;
            proto_err  <= 1'b0;
            cmp_count  <= 16'h0000;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
            if (accept) begin
                cmp_a      <= grant ? req_a1 : req_a0;
                cmp_b      <= grant ? req_b1 : req_b0;
                owner      <= grant;
                last_grant <= grant;
            end
            if (state == COMPARE) begin
                rsp_eq <= cmp_eq;
                rsp_gt <= cmp_gt;
                rsp_lt <= cmp_lt;
                if (!flags_onehot) proto_err <= 1'b1;
            end
            if (rsp_done && (cmp_count != 16'hFFFF)) cmp_count <= cmp_count + 16'h0001;
        end
    end
endmodule

// File: tb/tb_cmp_scheduler.sv
// tb/tb_cmp_scheduler.sv - scoreboard bench for cmp_scheduler
module tb_cmp_scheduler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v0 = 1'b0, v1 = 1'b0;
    logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [1:0]  req_valid, req_ready, rsp_valid;
    logic [1:0]  rsp_ready = 2'b11;
    logic        rsp_eq, rsp_gt, rsp_lt;
    logic [15:0] cmp_a, cmp_b, cmp_count;
    logic        cmp_eq, cmp_gt, cmp_lt, busy, proto_err;
    logic        force_bad = 1'b0;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    logic [3:0] sb[$];
    int grant_log[$];
    int hs_cyc[$];
    bit saw_rsp0 = 0;

    assign req_valid = {v1, v0};
    assign cmp_eq = force_bad ? 1'b1 : (cmp_a == cmp_b);
    assign cmp_gt = force_bad ? 1'b1 : (cmp_a > cmp_b);
    assign cmp_lt = force_bad ? 1'b0 : (cmp_a < cmp_b);

    cmp_scheduler #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(a0), .req_b0(b0), .req_a1(a1), .req_b1(b1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_eq(rsp_eq), .rsp_gt(rsp_gt), .rsp_lt(rsp_lt),
        .cmp_a(cmp_a), .cmp_b(cmp_b),
        .cmp_eq(cmp_eq), .cmp_gt(cmp_gt), .cmp_lt(cmp_lt),
        .busy(busy), .proto_err(proto_err), .cmp_count(cmp_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pop the scoreboard on every completed response handshake
    always @(negedge clk) begin
        if (rst_n && rsp_valid[0]) saw_rsp0 = 1;
        if (rst_n && ((rsp_valid & rsp_ready) != 2'b00)) begin
            hs_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                chk("unexpected_rsp", {30'd0, rsp_valid}, 32'd0);
            end else begin
                logic [3:0] e;
                e = sb.pop_front();
                chk("rsp_port", {31'd0, rsp_valid[1]}, {31'd0, e[3]});
                chk("rsp_flags", {29'd0, rsp_eq, rsp_gt, rsp_lt}, {29'd0, e[2:0]});
                chk("rsp_valid_onehot", {30'd0, rsp_valid}, e[3] ? 32'd2 : 32'd1);
            end
        end
    end

    task automatic do_req(input int p, input logic [15:0] a, input logic [15:0] b, input logic [2:0] exp);
        int n;
        @(negedge clk);
        if (p == 0) begin v0 = 1'b1; a0 = a; b0 = b; end
        else        begin v1 = 1'b1; a1 = a; b1 = b; end
        n = 0;
        forever begin
            #1;
            if (req_ready[p]) break;
            n++;
            if (n > 60) begin
                chk("req_timeout", 32'd0, 32'd1);
                if (p == 0) v0 = 1'b0; else v1 = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        sb.push_back({p[0], exp});
        grant_log.push_back(p);
        if (p == 0) v0 = 1'b0; else v1 = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk("drain", {31'd0, (sb.size() == 0 && !busy)}, 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset values; a pending request must not be granted before the first edge
        v0 = 1'b1; a0 = 16'd10; b0 = 16'd20;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("rst_flags", {29'd0, rsp_eq, rsp_gt, rsp_lt}, 32'd0);
        chk("rst_cmp_ab", {cmp_a, cmp_b}, 32'd0);
        chk("rst_busy_err", {30'd0, busy, proto_err}, 32'd0);
        chk("rst_count", {16'd0, cmp_count}, 32'd0);

        // Port 0 single request: 10 < 20
        do_req(0, 16'd10, 16'd20, 3'b001);
        chk("t1_cmp_a", {16'd0, cmp_a}, 32'd10);
        chk("t1_cmp_b", {16'd0, cmp_b}, 32'd20);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_no_rsp_yet", {30'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        chk("t1_rsp_valid", {30'd0, rsp_valid}, 32'd1);
        @(posedge clk); #1;
        chk("t1_count", {16'd0, cmp_count}, 32'd1);
        chk("t1_idle", {31'd0, busy}, 32'd0);

        // Back-to-back port 1: equal then greater, 3 cycles apart
        drain();
        saw_rsp0 = 0;
        hs_cyc.delete();
        do_req(1, 16'd100, 16'd100, 3'b100);
        do_req(1, 16'd110, 16'd20, 3'b010);
        drain();
        chk("t2_hs_count", hs_cyc.size(), 32'd2);
        if (hs_cyc.size() == 2) chk("t2_spacing", hs_cyc[1] - hs_cyc[0], 32'd3);
        chk("t2_no_rsp0", {31'd0, saw_rsp0}, 32'd0);
        chk("t2_count", {16'd0, cmp_count}, 32'd3);

        // Both ports requesting continuously from reset: strict alternation
        do_reset();
        grant_log.delete();
        fork
            begin
                do_req(0, 16'd5, 16'd5, 3'b100);
                do_req(0, 16'd5, 16'd5, 3'b100);
            end
            begin
                do_req(1, 16'd7, 16'd3, 3'b010);
                do_req(1, 16'd7, 16'd3, 3'b010);
            end
        join
        drain();
        chk("t3_grants", grant_log.size(), 32'd4);
        if (grant_log.size() == 4) begin
            chk("t3_g0", grant_log[0], 32'd0);
            chk("t3_g1", grant_log[1], 32'd1);
            chk("t3_g2", grant_log[2], 32'd0);
            chk("t3_g3", grant_log[3], 32'd1);
        end

        // Response back-pressure on port 0 while port 1 waits
        rsp_ready = 2'b10;
        do_req(0, 16'd30, 16'd30, 3'b100);
        @(negedge clk);
        v1 = 1'b1; a1 = 16'd1; b1 = 16'd2;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("t4_rsp_held", {30'd0, rsp_valid}, 32'd1);
            chk("t4_flags_held", {29'd0, rsp_eq, rsp_gt, rsp_lt}, 32'd4);
            chk("t4_no_ready", {30'd0, req_ready}, 32'd0);
            chk("t4_busy", {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        rsp_ready = 2'b11;
        do_req(1, 16'd1, 16'd2, 3'b001);
        drain();

        // Reset during COMPARE drops the transaction
        do_req(0, 16'd9, 16'd4, 3'b010);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_cmp_a", {16'd0, cmp_a}, 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("t5_no_rsp", {30'd0, rsp_valid}, 32'd0);

        // Non-one-hot comparator flags set a sticky protocol error
        force_bad = 1'b1;
        do_req(0, 16'd3, 16'd3, 3'b110);
        drain();
        force_bad = 1'b0;
        chk("t6_err_set", {31'd0, proto_err}, 32'd1);
        do_req(1, 16'd4, 16'd9, 3'b001);
        drain();
        chk("t6_err_sticky", {31'd0, proto_err}, 32'd1);
        do_reset();
        #1;
        chk("t6_err_cleared", {31'd0, proto_err}, 32'd0);

        chk("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end
endmodule
